// File: rtl/sdram_selftest_top_if.sv
// sdram_selftest_top_if: SDRAM command/address/control pin group.
// The controller drives it through the master modport. A memory model or
// board-level observer uses the slave modport.
interface sdram_selftest_top_if;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [11:0] addr;
  logic [1:0]  bank;
  logic        cke;
  logic        sclk;
  logic        ldqm;
  logic        udqm;

  modport master (
    output cs_n, ras_n, cas_n, we_n, addr, bank, cke, sclk, ldqm, udqm
  );

  modport slave (
    input cs_n, ras_n, cas_n, we_n, addr, bank, cke, sclk, ldqm, udqm
  );
endinterface

// File: rtl/sdram_selftest_top.sv
// sdram_selftest_top: power-up init sequence plus a single-word
// write / read-back / compare self-test at bank 0, row 0, column 0.
// The result is shown on two active-low LEDs.
// Optional macro SDRAM_AUTO_REFRESH_EN enables a periodic auto-refresh.
// The refresh is serviced from IDLE ahead of any button request.

module sdram_selftest_rw #(
  parameter int          TRCD         = 2,
  parameter int          TWR_TRP      = 4,
  parameter int          TRFC         = 4,
  parameter logic [15:0] TEST_PATTERN = 16'hCAFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic [1:0]  buttons,
  input  logic        ref_tick,
  input  logic [15:0] dq_in,
  output logic [3:0]  cmd_q,
  output logic [11:0] addr_q,
  output logic        dq_oe_q,
  output logic        test_pass_led_q,
  output logic        write_done_led_q
);
  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_ACT     = 4'b0011;
  localparam logic [3:0] CMD_READ    = 4'b0101;
  localparam logic [3:0] CMD_WRITE   = 4'b0100;
  localparam logic [3:0] CMD_REF     = 4'b0001;

  typedef enum logic [3:0] {
    IDLE, WR_ACT, WR_TRCD, WRITE, WR_WAIT,
    RD_ACT, RD_TRCD, RD_CMD, READ, COMPARE
  } state_t;

  state_t      state;
  logic [7:0]  cnt_q;
  logic [7:0]  ref_wait_q;
  logic        ref_pend_q;
  logic [15:0] rd_data_q;

  // Read/write FSM. Outputs are registered and belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cmd_q            <= CMD_INHIBIT;
      addr_q           <= 12'h000;
      dq_oe_q          <= 1'b0;
      test_pass_led_q  <= 1'b1;
      write_done_led_q <= 1'b1;
      cnt_q            <= 8'd0;
      ref_wait_q       <= 8'd0;
      ref_pend_q       <= 1'b0;
      rd_data_q        <= 16'h0000;
    end else begin
      cmd_q   <= CMD_NOP;
      addr_q  <= 12'h000;
      dq_oe_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ref_wait_q != 8'd0) begin
            ref_wait_q <= ref_wait_q - 8'd1;
          end else if (ref_pend_q) begin
            cmd_q      <= CMD_REF;
            ref_pend_q <= 1'b0;
            ref_wait_q <= 8'(TRFC);
          end else if (init_done && buttons[0]) begin
            state <= WR_ACT;
            cmd_q <= CMD_ACT;
          end else if (init_done && buttons[1]) begin
            state <= RD_ACT;
            cmd_q <= CMD_ACT;
          end else begin
            state <= IDLE;
          end
        end
        WR_ACT: begin
          state <= WR_TRCD;
          cnt_q <= 8'd0;
        end
        WR_TRCD: begin
          if (cnt_q == 8'(TRCD - 1)) begin
            state   <= WRITE;
            cmd_q   <= CMD_WRITE;
            addr_q  <= 12'h400;
            dq_oe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WRITE: begin
          state <= WR_WAIT;
          cnt_q <= 8'd0;
        end
        WR_WAIT: begin
          if (cnt_q == 8'(TWR_TRP - 1)) begin
            state            <= IDLE;
            write_done_led_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RD_ACT: begin
          state <= RD_TRCD;
          cnt_q <= 8'd0;
        end
        RD_TRCD: begin
          if (cnt_q == 8'(TRCD - 1)) begin
            state  <= RD_CMD;
            cmd_q  <= CMD_READ;
            addr_q <= 12'h400;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RD_CMD: begin
          state <= READ;
        end
        READ: begin
          // CAS latency 2 from the READ edge: data is valid on this edge.
          rd_data_q <= dq_in;
          state     <= COMPARE;
        end
        COMPARE: begin
          test_pass_led_q <= (rd_data_q == TEST_PATTERN) ? 1'b0 : 1'b1;
          state           <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A new tick wins over a same-cycle service so no interval is lost.
      if (ref_tick) begin
        ref_pend_q <= 1'b1;
      end
    end
  end
endmodule

module sdram_selftest_top #(
  parameter int          INIT_WAIT    = 10000,
  parameter int          TRP          = 2,
  parameter int          TRFC         = 4,
  parameter int          TMRD         = 2,
  parameter int          TRCD         = 2,
  parameter int          TWR_TRP      = 4,
  parameter logic [15:0] TEST_PATTERN = 16'hCAFE
) (
  input  logic                        clk_50MHz,
  input  logic                        reset,
  input  logic [1:0]                  buttons,
  output logic                        test_pass_led,
  output logic                        write_done_led,
  sdram_selftest_top_if.master        sd,
  inout  wire  [15:0]                 dq
);
  localparam logic [3:0] CMD_INHIBIT = 4'b1111;
  localparam logic [3:0] CMD_NOP     = 4'b0111;
  localparam logic [3:0] CMD_PRE     = 4'b0010;
  localparam logic [3:0] CMD_REF     = 4'b0001;
  localparam logic [3:0] CMD_LMR     = 4'b0000;

  typedef enum logic [3:0] {
    I_WAIT, I_PRE, I_TRP, I_REF1, I_TRFC1, I_REF2, I_TRFC2, I_LMR, I_TMRD, I_DONE
  } init_state_t;

  init_state_t init_state_q;
  logic [15:0] init_cnt_q;
  logic [3:0]  init_cmd_q;
  logic [11:0] init_addr_q;
  logic        cke_q;
  logic        dqm_q;
  logic        init_done_q;
  logic [1:0]  bank_q;
  logic        init_done;

  logic [3:0]  rw_cmd;
  logic [11:0] rw_addr;
  logic        rw_dq_oe;
  logic        ref_tick;

  assign init_done = init_done_q;

  // Power-up sequence: NOP wait, PRE all, two REFs, LMR, then hand over.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      init_state_q <= I_WAIT;
      init_cnt_q   <= 16'd0;
      init_cmd_q   <= CMD_INHIBIT;
      init_addr_q  <= 12'h000;
      cke_q        <= 1'b0;
      dqm_q        <= 1'b1;
      init_done_q  <= 1'b0;
      bank_q       <= 2'b00;
    end else begin
      cke_q       <= 1'b1;
      bank_q      <= 2'b00;
      init_cmd_q  <= CMD_NOP;
      init_addr_q <= 12'h000;
      case (init_state_q)
        I_WAIT: begin
          if (init_cnt_q == 16'(INIT_WAIT - 1)) begin
            init_state_q <= I_PRE;
            init_cnt_q   <= 16'd0;
          end else begin
            init_cnt_q <= init_cnt_q + 16'd1;
          end
        end
        I_PRE: begin
          init_cmd_q   <= CMD_PRE;
          init_addr_q  <= 12'h400;
          init_state_q <= I_TRP;
        end
        I_TRP: begin
          if (init_cnt_q == 16'(TRP - 1)) begin
            init_state_q <= I_REF1;
            init_cnt_q   <= 16'd0;
          end else begin
            init_cnt_q <= init_cnt_q + 16'd1;
          end
        end
        I_REF1: begin
          init_cmd_q   <= CMD_REF;
          init_state_q <= I_TRFC1;
        end
        I_TRFC1: begin
          if (init_cnt_q == 16'(TRFC - 1)) begin
            init_state_q <= I_REF2;
            init_cnt_q   <= 16'd0;
          end else begin
            init_cnt_q <= init_cnt_q + 16'd1;
          end
        end
        I_REF2: begin
          init_cmd_q   <= CMD_REF;
          init_state_q <= I_TRFC2;
        end
        I_TRFC2: begin
          if (init_cnt_q == 16'(TRFC - 1)) begin
            init_state_q <= I_LMR;
            init_cnt_q   <= 16'd0;
          end else begin
            init_cnt_q <= init_cnt_q + 16'd1;
          end
        end
        I_LMR: begin
          // Burst length 1, sequential, CAS latency 2, burst write.
          init_cmd_q   <= CMD_LMR;
          init_addr_q  <= 12'h020;
          init_state_q <= I_TMRD;
        end
        I_TMRD: begin
          if (init_cnt_q == 16'(TMRD - 1)) begin
            init_state_q <= I_DONE;
            init_cnt_q   <= 16'd0;
          end else begin
            init_cnt_q <= init_cnt_q + 16'd1;
          end
        end
        I_DONE: begin
          init_done_q <= 1'b1;
          dqm_q       <= 1'b0;
        end
        default: begin
          init_state_q <= I_WAIT;
        end
      endcase
    end
  end

`ifdef SDRAM_AUTO_REFRESH_EN
  localparam logic [9:0] REF_PERIOD = 10'd780;
  logic [9:0] ref_cnt_q;
  logic [9:0] ref_cnt_d;

  // Next value of the refresh-interval counter; idle until init completes.
  always_comb begin
    ref_cnt_d = ref_cnt_q;
    if (!init_done_q) begin
      ref_cnt_d = 10'd0;
    end else if (ref_cnt_q == REF_PERIOD - 10'd1) begin
      ref_cnt_d = 10'd0;
    end else begin
      ref_cnt_d = ref_cnt_q + 10'd1;
    end
  end

  // Refresh-interval counter register.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      ref_cnt_q <= 10'd0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
    end
  end

  assign ref_tick = init_done_q && (ref_cnt_q == REF_PERIOD - 10'd1);
`else
  assign ref_tick = 1'b0;
`endif

  sdram_selftest_rw #(
    .TRCD         (TRCD),
    .TWR_TRP      (TWR_TRP),
    .TRFC         (TRFC),
    .TEST_PATTERN (TEST_PATTERN)
  ) u_rw (
    .clk              (clk_50MHz),
    .reset            (reset),
    .init_done        (init_done_q),
    .buttons          (buttons),
    .ref_tick         (ref_tick),
    .dq_in            (dq),
    .cmd_q            (rw_cmd),
    .addr_q           (rw_addr),
    .dq_oe_q          (rw_dq_oe),
    .test_pass_led_q  (test_pass_led),
    .write_done_led_q (write_done_led)
  );

  // Both command sources are registered; the select is a register as well.
  assign {sd.cs_n, sd.ras_n, sd.cas_n, sd.we_n} = init_done_q ? rw_cmd : init_cmd_q;
  assign sd.addr = init_done_q ? rw_addr : init_addr_q;
  assign sd.bank = bank_q;
  assign sd.cke  = cke_q;
  assign sd.ldqm = dqm_q;
  assign sd.udqm = dqm_q;
  assign sd.sclk = ~clk_50MHz;
  assign dq      = rw_dq_oe ? TEST_PATTERN : 16'hzzzz;
endmodule

// File: tb/tb_sdram_selftest_top.sv
// Testbench for sdram_selftest_top: randomized button traffic against a
// behavioural model (command timeline from timing parameters, one-word memory).
module tb_sdram_selftest_top;
  localparam int IW   = 32;
  localparam int TRP  = 2;
  localparam int TRFC = 4;
  localparam int TMRD = 2;
  localparam int TRCD = 2;
  localparam int TWR  = 4;
  localparam int L    = IW + TRP + 2 * TRFC + TMRD + 4;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  buttons = 2'b00;
  logic        test_pass_led;
  logic        write_done_led;
  logic [15:0] tb_dq = 16'h0000;
  logic        tb_dq_en = 1'b0;
  wire  [15:0] dq;

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model state.
  logic [15:0] mem = 16'h0000;
  logic        exp_pass = 1'b1;
  logic        exp_wd = 1'b1;

  sdram_selftest_top_if sd_if ();

  sdram_selftest_top #(
    .INIT_WAIT (IW), .TRP (TRP), .TRFC (TRFC), .TMRD (TMRD),
    .TRCD (TRCD), .TWR_TRP (TWR), .TEST_PATTERN (16'hCAFE)
  ) dut (
    .clk_50MHz      (clk),
    .reset          (reset),
    .buttons        (buttons),
    .test_pass_led  (test_pass_led),
    .write_done_led (write_done_led),
    .sd             (sd_if),
    .dq             (dq)
  );

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;
  wire [3:0] cmd = {sd_if.cs_n, sd_if.ras_n, sd_if.cas_n, sd_if.we_n};

  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [3:0] exp_init(input int c);
    int p_pre;
    int p_r1;
    int p_r2;
    int p_lmr;
    p_pre = IW + 1;
    p_r1  = p_pre + TRP + 1;
    p_r2  = p_r1 + TRFC + 1;
    p_lmr = p_r2 + TRFC + 1;
    if (c == p_pre) return C_PRE;
    if (c == p_r1 || c == p_r2) return C_REF;
    if (c == p_lmr) return C_LMR;
    return C_NOP;
  endfunction

  task automatic hold_reset(input int ncyc);
    @(negedge clk);
    reset = 1'b1;
    buttons = 2'b00;
    tb_dq_en = 1'b0;
    repeat (ncyc) @(negedge clk);
    chk("rst_cmd", {28'h0, cmd}, {28'h0, C_INH});
    chk("rst_addr", {20'h0, sd_if.addr}, 32'h0);
    chk("rst_bank", {30'h0, sd_if.bank}, 32'h0);
    chk("rst_cke", {31'h0, sd_if.cke}, 32'h0);
    chk("rst_dqm", {30'h0, sd_if.ldqm, sd_if.udqm}, {30'h0, 2'b11});
    chk("rst_dq_hiz", {16'h0, dq}, {16'h0, 16'hzzzz});
    chk("rst_pass_led", {31'h0, test_pass_led}, 32'h1);
    chk("rst_wd_led", {31'h0, write_done_led}, 32'h1);
    chk("rst_init_done", {31'h0, dut.init_done}, 32'h0);
    chk("sclk", {31'h0, sd_if.sclk}, 32'h1);
    exp_pass = 1'b1;
    exp_wd = 1'b1;
    reset = 1'b0;
  endtask

  task automatic check_init();
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clk);
      chk("init_cmd", {28'h0, cmd}, {28'h0, exp_init(c)});
      chk("init_cke", {31'h0, sd_if.cke}, 32'h1);
      if (exp_init(c) == C_PRE) chk("pre_a10", {31'h0, sd_if.addr[10]}, 32'h1);
      if (exp_init(c) == C_LMR) chk("lmr_addr", {20'h0, sd_if.addr}, 32'h020);
      if (c == L) begin
        chk("init_done_lo", {31'h0, dut.init_done}, 32'h0);
        chk("dqm_hi", {30'h0, sd_if.ldqm, sd_if.udqm}, {30'h0, 2'b11});
      end
      if (c == L + 1) begin
        chk("init_done_hi", {31'h0, dut.init_done}, 32'h1);
        chk("dqm_lo", {30'h0, sd_if.ldqm, sd_if.udqm}, 32'h0);
      end
      // Buttons while initialising must be ignored.
      buttons = (c < L - 2) ? 2'($urandom_range(0, 3)) : 2'b00;
    end
  endtask

  // Write request; abort_n > 0 asserts reset at that cycle instead of finishing.
  task automatic do_write(input logic [1:0] btn, input int abort_n);
    int led_n;
    led_n = 3 + TRCD + TWR;
    @(negedge clk);
    buttons = btn;
    for (int n = 1; n <= led_n + 1; n++) begin
      @(negedge clk);
      if (abort_n > 0 && n == abort_n) begin
        hold_reset(3);
        return;
      end
      chk("wr_cmd", {28'h0, cmd},
          {28'h0, (n == 1) ? C_ACT : (n == TRCD + 2) ? C_WR : C_NOP});
      chk("wr_bank", {30'h0, sd_if.bank}, 32'h0);
      if (n == 1) chk("act_row", {20'h0, sd_if.addr}, 32'h0);
      if (n == TRCD + 2) begin
        chk("wr_addr", {20'h0, sd_if.addr}, 32'h400);
        chk("wr_dq", {16'h0, dq}, 32'hCAFE);
      end else begin
        chk("wr_dq_hiz", {16'h0, dq}, {16'h0, 16'hzzzz});
      end
      if (n == led_n - 1) chk("wd_led_hold", {31'h0, write_done_led}, {31'h0, exp_wd});
      if (n == led_n) begin
        exp_wd = 1'b0;
        mem = 16'hCAFE;
        chk("wd_led_fall", {31'h0, write_done_led}, 32'h0);
      end
      if (n == 2 || n == 5) buttons = 2'b00;
      if (n == 3 || n == 4) buttons = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic do_read(input logic [15:0] v);
    int k_n;
    k_n = TRCD + 2;
    @(negedge clk);
    buttons = 2'b10;
    for (int n = 1; n <= k_n + 4; n++) begin
      @(negedge clk);
      chk("rd_cmd", {28'h0, cmd},
          {28'h0, (n == 1) ? C_ACT : (n == k_n) ? C_RD : C_NOP});
      if (n == k_n) begin
        chk("rd_addr", {20'h0, sd_if.addr}, 32'h400);
        chk("rd_dq_hiz", {16'h0, dq}, {16'h0, 16'hzzzz});
      end
      if (n == k_n + 2) chk("pass_led_hold", {31'h0, test_pass_led}, {31'h0, exp_pass});
      if (n == k_n + 3) begin
        exp_pass = (v == 16'hCAFE) ? 1'b0 : 1'b1;
        chk("pass_led", {31'h0, test_pass_led}, {31'h0, exp_pass});
        chk("wd_led_keep", {31'h0, write_done_led}, {31'h0, exp_wd});
        tb_dq_en = 1'b0;
      end
      if (n == k_n + 1) begin
        tb_dq = v;
        tb_dq_en = 1'b1;
      end
      if (n == 2 || n == 5) buttons = 2'b00;
      if (n == 3 || n == 4) buttons = 2'($urandom_range(0, 3));
    end
  endtask

  function automatic logic [15:0] bad_word();
    logic [15:0] w;
    w = 16'($urandom());
    if (w == 16'hCAFE) w = 16'hCAFF;
    return w;
  endfunction

  initial begin
    hold_reset(4);
    check_init();
    do_read(mem);                 // nothing written yet
    do_write(2'b01, 0);
    do_read(mem);                 // pattern read back
    do_read(16'h1234);            // wrong data
    do_write(2'b11, 0);           // both buttons: write wins
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      case ($urandom_range(0, 2))
        0: do_write(2'b01, 0);
        1: do_write(2'b11, 0);
        default: do_read(($urandom_range(0, 2) != 0) ? mem : bad_word());
      endcase
    end
    do_write(2'b01, TRCD + 4);    // reset during WR_WAIT
    check_init();
    do_read(mem);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
